// File: rtl/spike_rate_decoder_pkg.sv
// Shared constants for the spike-rate decoder.
// FSM encoding is kept as plain localparams for legacy tools.
package spike_rate_decoder_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int DEF_WIN_CYCLES = 16;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_ISI_W      = 8;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Output packet channel of the spike-rate decoder.
// Plain valid/ready with rate and ISI payload.
interface spike_rate_decoder_if
    import spike_rate_decoder_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int ISI_W = DEF_ISI_W
);

    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_rate;
    logic [ISI_W-1:0] out_isi;

    modport master (
        output out_valid,
        output out_rate,
        output out_isi,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_rate,
        input  out_isi,
        output out_ready
    );

endinterface

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter with clear and load.
// nxt_o is the incremented value before clear/load are applied.
module spike_rate_decoder_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] nxt_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign nxt_o = (inc_i && (q_q != MAX)) ? q_q + W'(1) : q_q;

    always_comb begin
        q_d = nxt_o;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = load_val_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Turns a neuron spike train back into a per-window rate
// and the most recent inter-spike interval.
module spike_rate_decoder
    import spike_rate_decoder_pkg::*;
#(
    parameter int WIN_CYCLES = DEF_WIN_CYCLES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int ISI_W      = DEF_ISI_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 spike_in,
    spike_rate_decoder_if.master out_if,
    output logic                 overrun
);

    localparam int             WW    = $clog2(WIN_CYCLES);
    localparam logic [WW-1:0]  WLAST = WW'(WIN_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic             prev_q, prev_d;
    logic             have_q, have_d;
    logic             ovr_q, ovr_d;
    logic [ISI_W-1:0] isi_last_q, isi_last_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic [ISI_W-1:0] oisi_q, oisi_d;

    logic             run;
    logic             spk_edge;
    logic             close;
    logic             xfer;
    logic             take;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ISI_W-1:0] isi_nxt;
    logic [ISI_W-1:0] isi_now;

    assign run      = (state_q == ST_RUN);
    assign spk_edge = run & spike_in & ~prev_q;
    assign close    = run & (wcnt_q == WLAST);
    assign xfer     = vld_q & out_if.out_ready;
    assign take     = close & (~vld_q | out_if.out_ready);

    spike_rate_decoder_sat_counter #(
        .W (CNT_W)
    ) u_spike_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (~run | close),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (spk_edge),
        .nxt_o      (cnt_nxt)
    );

    // Counts cycles since the last edge; nxt_o is the ISI of a new edge.
    spike_rate_decoder_sat_counter #(
        .W (ISI_W)
    ) u_isi_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (~run | spk_edge),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (run),
        .nxt_o      (isi_nxt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wcnt_d     = (!run || close) ? '0 : wcnt_q + WW'(1);
        prev_d     = run & spike_in;
        have_d     = run & (have_q | spk_edge);
        isi_now    = (spk_edge && have_q) ? isi_nxt : isi_last_q;
        isi_last_d = run ? isi_now : '0;
        ovr_d      = run & (ovr_q | (close & vld_q & ~out_if.out_ready));
    end

    // One-entry output buffer; a close may reload it in the transfer cycle.
    always_comb begin
        vld_d  = vld_q;
        rate_d = rate_q;
        oisi_d = oisi_q;
        if (take) begin
            vld_d  = 1'b1;
            rate_d = cnt_nxt;
            oisi_d = isi_now;
        end else if (xfer) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            prev_q     <= 1'b0;
            have_q     <= 1'b0;
            ovr_q      <= 1'b0;
            isi_last_q <= '0;
            vld_q      <= 1'b0;
            rate_q     <= '0;
            oisi_q     <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            prev_q     <= prev_d;
            have_q     <= have_d;
            ovr_q      <= ovr_d;
            isi_last_q <= isi_last_d;
            vld_q      <= vld_d;
            rate_q     <= rate_d;
            oisi_q     <= oisi_d;
        end
    end

    assign out_if.out_valid = vld_q;
    assign out_if.out_rate  = rate_q;
    assign out_if.out_isi   = oisi_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: wide and 3-bit instances
// share one stimulus and are compared to an event-level model.
module tb_spike_rate_decoder;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic spike = 1'b0;
    logic rdy   = 1'b0;
    logic ovr0, ovr1;

    spike_rate_decoder_if #(.CNT_W(8), .ISI_W(8)) bus0 ();
    spike_rate_decoder_if #(.CNT_W(3), .ISI_W(3)) bus1 ();

    assign bus0.out_ready = rdy;
    assign bus1.out_ready = rdy;

    spike_rate_decoder #(.WIN_CYCLES(W), .CNT_W(8), .ISI_W(8)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .spike_in (spike),
        .out_if   (bus0.master),
        .overrun  (ovr0)
    );

    spike_rate_decoder #(.WIN_CYCLES(W), .CNT_W(3), .ISI_W(3)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .spike_in (spike),
        .out_if   (bus1.master),
        .overrun  (ovr1)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string ph     = "init";
    int    lat;

    // Model: edge times since enable, edges per window, packet buffer.
    int mx [2] = '{255, 7};
    bit m_run  [2];
    int m_t    [2];
    bit m_prev [2];
    int m_cnt  [2];
    int m_last [2];
    int m_pen  [2];
    bit ev     [2];
    int er     [2];
    int ei     [2];
    bit eo     [2];

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_t[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
            m_last[k] = -1; m_pen[k] = -1;
            ev[k] = 0; er[k] = 0; ei[k] = 0; eo[k] = 0;
        end
    endtask

    task automatic m_step(bit e, bit s, bit r);
        for (int k = 0; k < 2; k++) begin
            if (m_run[k]) begin
                if (s && !m_prev[k]) begin
                    m_pen[k]  = m_last[k];
                    m_last[k] = m_t[k];
                    m_cnt[k]++;
                end
                m_prev[k] = s;
                if (m_t[k] % W == W - 1) begin
                    if (!ev[k] || r) begin
                        ev[k] = 1;
                        er[k] = min2(m_cnt[k], mx[k]);
                        ei[k] = (m_pen[k] >= 0) ?
                                min2(m_last[k] - m_pen[k], mx[k]) : 0;
                    end else begin
                        eo[k] = 1;
                    end
                    m_cnt[k] = 0;
                end else if (ev[k] && r) begin
                    ev[k] = 0;
                end
                m_t[k]++;
                if (!e) m_run[k] = 0;
            end else begin
                if (ev[k] && r) ev[k] = 0;
                eo[k] = 0;
                if (e) begin
                    m_run[k] = 1; m_t[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
                    m_last[k] = -1; m_pen[k] = -1;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk({ph, ".valid0"}, 32'(bus0.out_valid), 32'(ev[0]));
        chk({ph, ".rate0"},  32'(bus0.out_rate),  er[0]);
        chk({ph, ".isi0"},   32'(bus0.out_isi),   ei[0]);
        chk({ph, ".ovr0"},   32'(ovr0),           32'(eo[0]));
        chk({ph, ".valid1"}, 32'(bus1.out_valid), 32'(ev[1]));
        chk({ph, ".rate1"},  32'(bus1.out_rate),  er[1]);
        chk({ph, ".isi1"},   32'(bus1.out_isi),   ei[1]);
        chk({ph, ".ovr1"},   32'(ovr1),           32'(eo[1]));
    endtask

    task automatic cyc(bit e, bit s, bit r);
        en = e; spike = s; rdy = r;
        m_step(e, s, r);
        @(posedge clk);
        #1;
        chk_all();
    endtask

    initial begin
        m_reset();

        ph = "rst";
        @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;

        ph  = "lat";
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            cyc(1, 0, 1);
            if (bus0.out_valid === 1'b1) lat = i;
        end
        chk("first_pkt_lat", lat, 17);

        ph = "reg";
        for (int i = 0; i < 32; i++) cyc(1, (m_t[0] % 4) == 1, 1);
        chk("reg_valid", 32'(bus0.out_valid), 1);
        chk("reg_rate",  32'(bus0.out_rate), 4);
        chk("reg_isi",   32'(bus0.out_isi), 4);

        ph = "bp";
        for (int i = 0; i < 32; i++)
            cyc(1, (i == 2 || i == 6 || i == 18 || i == 20 || i == 23), i == 0);
        chk("bp_rate", 32'(bus0.out_rate), 2);
        chk("bp_ovr",  32'(ovr0), 1);
        cyc(1, 0, 1);
        chk("bp_drain", 32'(bus0.out_valid), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("bp_ovr_clr", 32'(ovr0), 0);

        ph = "sat";
        cyc(1, 0, 1);
        for (int i = 0; i < 16; i++) cyc(1, (i % 2) == 0, 1);
        chk("sat_rate1", 32'(bus1.out_rate), 7);
        chk("sat_rate0", 32'(bus0.out_rate), 8);
        for (int i = 0; i < 16; i++) cyc(1, (i == 0 || i == 10), 1);
        chk("sat_isi1", 32'(bus1.out_isi), 7);
        chk("sat_isi0", 32'(bus0.out_isi), 10);

        ph = "lvl";
        cyc(0, 0, 1);
        cyc(1, 1, 1);
        for (int i = 0; i < 16; i++) cyc(1, 1, 1);
        chk("lvl_rate_a", 32'(bus0.out_rate), 1);
        for (int i = 0; i < 16; i++) cyc(1, 1, 1);
        chk("lvl_rate_b", 32'(bus0.out_rate), 0);
        chk("lvl_isi",    32'(bus0.out_isi), 0);

        ph = "cls";
        for (int i = 0; i < 32; i++)
            cyc(1, (i == 5 || i == 19 || i == 31), (i < 16) || (i == 31));
        chk("cls_valid", 32'(bus0.out_valid), 1);
        chk("cls_rate",  32'(bus0.out_rate), 2);
        chk("cls_isi",   32'(bus0.out_isi), 12);
        chk("cls_ovr",   32'(ovr0), 0);

        ph    = "arst";
        en    = 1'b1;
        spike = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("arst_valid0", 32'(bus0.out_valid), 0);
        chk("arst_rate0",  32'(bus0.out_rate), 0);
        chk("arst_isi0",   32'(bus0.out_isi), 0);
        chk("arst_ovr0",   32'(ovr0), 0);
        chk("arst_valid1", 32'(bus1.out_valid), 0);
        spike = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;

        ph = "rand";
        for (int i = 0; i < 700; i++) begin
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Decodes the spike train emitted by the LSNN neuron back into numeric form: spike rate per fixed window plus most recent inter-spike interval (ISI).
- Sits downstream of the neuron's spike output; output packets go to a consumer (readout/host logic) via a valid/ready handshake.
- Acts as the decoder for the neuron, which encodes input current into spikes.

Parameters:
- WIN_CYCLES, 16, window length in clock cycles (>=2).
- CNT_W, 8, width of the spike-count field; saturating.
- ISI_W, 8, width of the ISI field; saturating.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  decoder enable; low = IDLE.
- spike_in  input  1  spike line from the neuron (one bit of uo_out).
- out_ready  input  1  consumer accepts the packet.
- out_valid  output  1  packet held on out_rate/out_isi.
- out_rate  output  CNT_W  rising edges counted in the last completed window.
- out_isi  output  ISI_W  last measured ISI in cycles; 0 if fewer than two edges seen since enable.
- overrun  output  1  sticky: a completed window was dropped because the packet was not consumed.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, out_rate=0, out_isi=0, overrun=0; all internal counters and prev_spike=0.
- Spike event: edge = spike_in & ~prev_spike. prev_spike is registered every cycle while RUN and cleared in IDLE. A level held high counts once.
- FSM: IDLE -> RUN when en=1. The window starts that cycle, so wcnt=0 covers that cycle. RUN -> IDLE when en=0.
- IDLE clears wcnt, spike_cnt, isi_cnt, have_first and prev_spike, and clears overrun.
- The output register is not touched by IDLE. A pending packet stays valid until accepted.
- Window: wcnt increments in RUN each cycle and wraps at WIN_CYCLES-1.
- Close cycle (wcnt==WIN_CYCLES-1): result = sat(spike_cnt + edge). spike_cnt <= 0 for the next window.
- Otherwise spike_cnt <= sat(spike_cnt + edge). Saturation is at 2^CNT_W-1.
- ISI: isi_cnt increments each RUN cycle, saturating at 2^ISI_W-1.
  - On edge: if have_first=1, isi_last <= isi_cnt + 1 (saturating). Then isi_cnt <= 0 and have_first <= 1.
  - Hence edges 4 cycles apart give ISI=4.
- Output handshake, one-entry buffer:
  - Transfer occurs when out_valid & out_ready.
  - On close cycle, if out_valid=0 or out_ready=1: the next cycle has out_valid=1, out_rate=result, out_isi=isi_last, including an edge on the close cycle itself. Latency is 1 cycle after the close cycle.
  - On close cycle, if out_valid=1 and out_ready=0: the result is dropped, overrun <= 1, and the held packet is unchanged.
  - Transfer without a close: out_valid <= 0 next cycle. out_rate/out_isi keep their last values.
  - Outputs are stable while out_valid=1 and out_ready=0.
- en falling on the close cycle: that close is still processed (en sampled same cycle). The next cycle is IDLE.
- Reset mid-window: everything returns to reset values immediately; no partial packet is emitted.

Decomposition:
- Package spike_dec_pkg: state enum (IDLE, RUN); a saturating-add function, or constants for the max values of CNT_W/ISI_W.
- One sub-module is natural: sat_counter (parameterised width; inc, clr, load inputs; saturating). Instantiate it for spike_cnt and isi_cnt.

Test Plan (WIN_CYCLES=16 unless stated):
1. Reset: hold rst_n=0 mid-activity with en=1, spike_in toggling -> out_valid=0, out_rate=0, out_isi=0, overrun=0 asynchronously. After release with en=1, the first packet appears exactly 17 cycles later.
2. Regular rate: en=1, out_ready=1, 1-cycle spikes on window cycles 1,5,9,13 -> out_valid pulses 1 cycle after cycle 15 with out_rate=4, out_isi=4. Repeat for the next window -> same values.
3. Backpressure: out_ready=0 for two windows with 2 and 3 spikes -> packet rate=2 held steady, overrun=1 after the second close. Raise out_ready -> one transfer, out_valid=0. en=0 -> overrun=0.
4. Saturation: CNT_W=3, spike_in alternating 1/0 for a full window (8 edges) -> out_rate=7. ISI_W=3 with spikes 10 cycles apart -> out_isi=7.
5. Level hold: spike_in=1 for all 16 window cycles -> out_rate=1. Next window, still high -> out_rate=0; out_isi=0 (single edge).
6. Edge on close cycle plus simultaneous transfer: pending packet with out_ready=1 at the close, spike edge on cycle 15 -> old packet transferred, new packet loaded next cycle counting that edge, no overrun.
